wb_lsu: RTL
===========

// Module: wb_lsu
// PURPOSE
//  Parametrised Wishbone B4 classic load/store unit; next-generation replacement for the CPU's inline memory stage.
//  Accepts one load/store request from the core and runs the bus cycle(s).
//  Handles lane steering and sign extension, splits misaligned accesses, retries on rty_i, and reports err_i.
//  Sits between the cpu execute stage and the shared Wishbone interconnect.
// PARAMETERS
//  DATA_W            32  bus/data width; 32 or 64 only
//  MAX_RETRY         3   rty_i responses tolerated per beat before giving up (0..15)
//  SPLIT_MISALIGNED  1   1: misaligned access split into two beats; 0: rejected with LSU_ERR_MISALIGN
// PORTS
//  clk_i           in   1         single clock, all logic on rising edge
//  rst_ni          in   1         synchronous, active-low reset
//  req_valid_i     in   1         request present
//  req_ready_o     out  1         high only in IDLE; transfer when valid&ready
//  req_we_i        in   1         1 store, 0 load
//  req_size_i      in   2         0 byte, 1 half, 2 word, 3 dword (DATA_W=64 only)
//  req_unsigned_i  in   1         load zero-extends when 1
//  req_addr_i      in   32        byte address
//  req_wdata_i     in   DATA_W    store data, LSB-aligned
//  rsp_valid_o     out  1         one-cycle pulse, request complete
//  rsp_rdata_o     out  DATA_W    load result, extended; 0 for stores/errors
//  rsp_err_o       out  2         LSU_ERR_NONE/BUS/RETRY/MISALIGN
//  cyc_o, stb_o    out  1         Wishbone cycle/strobe, registered
//  we_o            out  1         registered
//  adr_o           out  32        DATA_W/8-aligned word address, registered
//  sel_o           out  DATA_W/8  byte lane enables, registered
//  dat_o           out  DATA_W    lane-shifted store data, registered
//  dat_i           in   DATA_W    read data
//  ack_i, err_i, rty_i in 1       termination; priority err_i > rty_i > ack_i
// BEHAVIOUR
//  Reset (rst_ni=0 at edge): state IDLE; cyc_o,stb_o,we_o,sel_o,adr_o,dat_o,rsp_valid_o,rsp_err_o,rsp_rdata_o = 0; retry count 0.
//  Reset mid-cycle drops cyc_o/stb_o on that edge; no response is issued.
//  FSM: IDLE -> BEAT0 -> [BEAT1] -> RESP -> IDLE; WAIT_RTY is entered from either beat.
//  IDLE: on valid&ready, latch request. Illegal size (3 with DATA_W=32) -> RESP with ERR_MISALIGN.
//   Misaligned with SPLIT_MISALIGNED=0 -> RESP with ERR_MISALIGN. Neither case starts a bus cycle.
//  BEAT0: cyc_o/stb_o rise the edge after accept; held until a termination.
//   ack: if access crosses a DATA_W/8 boundary -> BEAT1 (cyc_o stays high, adr_o += DATA_W/8), else RESP.
//  BEAT1: upper part of split access; sel_o/dat_o carry the remaining low lanes. ack -> RESP.
//  rty_i: drop stb_o (cyc_o held) for one cycle in WAIT_RTY, increment count, re-issue the same beat.
//   Count resets per beat. rty when count==MAX_RETRY -> RESP with ERR_RETRY.
//  err_i in any beat -> RESP with ERR_BUS, remaining beat skipped.
//   A completed first store beat is NOT rolled back.
//  RESP: cyc_o/stb_o low; rsp_valid_o=1 for exactly one cycle; next cycle IDLE, ready again.
//  Latency, aligned access, zero-wait slave: accept N, stb N+1, ack N+1, rsp_valid N+2.
//  Throughput is one request per 3 cycles.
//  Terminations seen while stb_o=0 are ignored.
//  Load data: beat0 lanes captured at ack, merged with beat1 lanes.
//   Result = bytes [addr .. addr+size) little-endian, then sign/zero extended to DATA_W.
//  sel_o: ((1<<bytes)-1) << offset, split across beats at boundary; dat_o shifted by 8*offset identically.
// STRUCTURE
//  params.vh: LSU_SIZE_B/H/W/D, LSU_ERR_NONE=0/BUS=1/RETRY=2/MISALIGN=3, LSU state encodings.
//  Sub-module lsu_lane_align (combinational): offset, size, unsigned -> sel masks for both beats,
//   shifted store data, merged/extended load data. FSM and counters stay in wb_lsu.
// TESTING
//  1 LW addr 0x104, dat_i=0xDEADBEEF, ack 1st cycle -> adr 0x104, sel 1111, rsp_rdata 0xDEADBEEF, err 0, rsp 2 cycles after accept.
//  2 LB addr 0x103, dat_i=0x80000000 -> sel 1000, rdata 0xFFFFFF80; LBU same -> 0x00000080.
//  3 SW 0x11223344 addr 0x202, split=1 -> beat0 adr 0x200 sel 1100 dat 0x33440000; beat1 adr 0x204 sel 0011 dat 0x00001122.
//  4 SH addr 0x201 with split=0 -> no cyc_o, rsp_err MISALIGN, rdata 0.
//  5 LW with rty_i on 4 consecutive beats, MAX_RETRY=3 -> 3 re-issues with stb gap, then rsp_err RETRY.
//  6 split LW, err_i on beat1 -> rsp_err BUS, no third beat; rst_ni low mid-beat0 -> cyc_o 0 next edge, no rsp_valid.

Source files
------------

// File: rtl/wb_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_lsu_pkg
//  Description : Shared constants, state encoding and helpers for wb_lsu.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_lsu_pkg;

    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;
    localparam logic [1:0] LSU_SIZE_D = 2'd3;

    localparam logic [1:0] LSU_ERR_NONE     = 2'd0;
    localparam logic [1:0] LSU_ERR_BUS      = 2'd1;
    localparam logic [1:0] LSU_ERR_RETRY    = 2'd2;
    localparam logic [1:0] LSU_ERR_MISALIGN = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BEAT0    = 3'd1,
        ST_BEAT1    = 3'd2,
        ST_WAIT_RTY = 3'd3,
        ST_RESP     = 3'd4
    } lsu_state_t;

    function automatic int size_bytes(input logic [1:0] size);
        return 32'sd1 << size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_lsu_req_if / wb_lsu_bus_if
//  Description : Core-side request/response and Wishbone B4 classic bundles.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_lsu_req_if #(parameter int DATA_W = 32) ();
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;
    logic [31:0]       req_addr_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic              rsp_valid_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic [1:0]        rsp_err_o;

    // master = execute stage, slave = load/store unit
    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

interface wb_lsu_bus_if #(parameter int DATA_W = 32) ();
    logic                cyc_o;
    logic                stb_o;
    logic                we_o;
    logic [31:0]         adr_o;
    logic [DATA_W/8-1:0] sel_o;
    logic [DATA_W-1:0]   dat_o;
    logic [DATA_W-1:0]   dat_i;
    logic                ack_i;
    logic                err_i;
    logic                rty_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        input  dat_i, ack_i, err_i, rty_i
    );
    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        output dat_i, ack_i, err_i, rty_i
    );
endinterface
`default_nettype wire

// File: rtl/wb_lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : wb_lsu_lane_align
//  Description : Combinational lane steering: byte enables and store data for
//                both beats, plus merged and sign/zero-extended load data.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_lsu_lane_align
    import wb_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] offset,
    input  logic [1:0]                  size,
    input  logic                        is_unsigned,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [DATA_W-1:0]           rdata_lo,
    input  logic [DATA_W-1:0]           rdata_hi,
    output logic [DATA_W/8-1:0]         sel0,
    output logic [DATA_W/8-1:0]         sel1,
    output logic [DATA_W-1:0]           wdata0,
    output logic [DATA_W-1:0]           wdata1,
    output logic [DATA_W-1:0]           rdata,
    output logic                        crosses,
    output logic                        misaligned
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    int                  nbytes;
    logic [NB-1:0]       byte_mask;
    logic [DATA_W-1:0]   bit_mask;
    logic [2*NB-1:0]     sel_wide;
    logic [2*DATA_W-1:0] wdata_wide;
    logic [2*DATA_W-1:0] rdata_wide;
    logic [DATA_W-1:0]   raw;
    logic                sign_bit;
    logic [OFF_W-1:0]    align_mask;

    always_comb begin
        nbytes    = size_bytes(size);
        byte_mask = '0;
        bit_mask  = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < nbytes) begin
                byte_mask[i]     = 1'b1;
                bit_mask[8*i +: 8] = 8'hFF;
            end
        end

        // A double-width window lets the access spill into the next bus word.
        sel_wide   = {{NB{1'b0}}, byte_mask} << offset;
        wdata_wide = {{DATA_W{1'b0}}, wdata & bit_mask} << {offset, 3'b000};
        rdata_wide = {rdata_hi, rdata_lo} >> {offset, 3'b000};

        sel0   = sel_wide[NB-1:0];
        sel1   = sel_wide[2*NB-1:NB];
        wdata0 = wdata_wide[DATA_W-1:0];
        wdata1 = wdata_wide[2*DATA_W-1:DATA_W];

        raw      = rdata_wide[DATA_W-1:0] & bit_mask;
        sign_bit = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (i == nbytes - 1) begin
                sign_bit = raw[8*i+7];
            end
        end
        rdata = (sign_bit && !is_unsigned) ? (raw | ~bit_mask) : raw;

        crosses    = |sel1;
        align_mask = OFF_W'(nbytes - 1);
        misaligned = |(offset & align_mask);
    end

endmodule
`default_nettype wire

// File: rtl/wb_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : wb_lsu
//  Description : Wishbone B4 classic load/store unit with misaligned split,
//                retry handling and bus error reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_lsu
    import wb_lsu_pkg::*;
#(
    parameter int DATA_W           = 32,
    parameter int MAX_RETRY        = 3,
    parameter int SPLIT_MISALIGNED = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    wb_lsu_req_if.slave  req,
    wb_lsu_bus_if.master bus
);

    localparam int         NB          = DATA_W / 8;
    localparam int         OFF_W       = $clog2(NB);
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);
    localparam bit         SPLIT_EN    = (SPLIT_MISALIGNED != 0);
    localparam bit         NO_DWORD    = (DATA_W == 32);

    lsu_state_t        state, state_n;
    logic              cyc, cyc_n, stb, stb_n, we, we_n;
    logic [31:0]       adr, adr_n;
    logic [NB-1:0]     sel, sel_n;
    logic [DATA_W-1:0] dat, dat_n;
    logic              rsp_valid, rsp_valid_n;
    logic [1:0]        rsp_err, rsp_err_n;
    logic [DATA_W-1:0] rsp_rdata, rsp_rdata_n;
    logic [3:0]        retry_cnt, retry_cnt_n;
    logic              second_beat, second_beat_n;
    logic [DATA_W-1:0] rdata0, rdata0_n;

    logic              lat_we, lat_unsigned;
    logic [1:0]        lat_size;
    logic [31:0]       lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              accept;
    logic [1:0]        al_size;
    logic              al_unsigned;
    logic [31:0]       al_addr;
    logic [DATA_W-1:0] al_wdata;
    logic [NB-1:0]     sel0, sel1;
    logic [DATA_W-1:0] wdata0, wdata1, load_data;
    logic              crosses, misaligned, illegal_size;

    logic              finish;
    logic [1:0]        finish_err;
    logic [DATA_W-1:0] finish_data;

    assign accept = (state == ST_IDLE) && req.req_valid_i;

    // In IDLE the aligner looks at the incoming request so the first beat can
    // be registered on the accept edge; afterwards it uses the latched copy.
    assign al_size      = (state == ST_IDLE) ? req.req_size_i     : lat_size;
    assign al_unsigned  = (state == ST_IDLE) ? req.req_unsigned_i : lat_unsigned;
    assign al_addr      = (state == ST_IDLE) ? req.req_addr_i     : lat_addr;
    assign al_wdata     = (state == ST_IDLE) ? req.req_wdata_i    : lat_wdata;
    assign illegal_size = NO_DWORD && (al_size == LSU_SIZE_D);

    wb_lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .offset      (al_addr[OFF_W-1:0]),
        .size        (al_size),
        .is_unsigned (al_unsigned),
        .wdata       (al_wdata),
        .rdata_lo    (second_beat ? rdata0 : bus.dat_i),
        .rdata_hi    (bus.dat_i),
        .sel0        (sel0),
        .sel1        (sel1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .rdata       (load_data),
        .crosses     (crosses),
        .misaligned  (misaligned)
    );

    always_comb begin
        state_n       = state;
        cyc_n         = cyc;
        stb_n         = stb;
        we_n          = we;
        adr_n         = adr;
        sel_n         = sel;
        dat_n         = dat;
        rsp_valid_n   = 1'b0;
        rsp_err_n     = rsp_err;
        rsp_rdata_n   = rsp_rdata;
        retry_cnt_n   = retry_cnt;
        second_beat_n = second_beat;
        rdata0_n      = rdata0;
        finish        = 1'b0;
        finish_err    = LSU_ERR_NONE;
        finish_data   = '0;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (illegal_size || (misaligned && !SPLIT_EN)) begin
                        finish     = 1'b1;
                        finish_err = LSU_ERR_MISALIGN;
                    end else begin
                        state_n       = ST_BEAT0;
                        cyc_n         = 1'b1;
                        stb_n         = 1'b1;
                        we_n          = req.req_we_i;
                        adr_n         = {req.req_addr_i[31:OFF_W], {OFF_W{1'b0}}};
                        sel_n         = sel0;
                        dat_n         = req.req_we_i ? wdata0 : '0;
                        retry_cnt_n   = '0;
                        second_beat_n = 1'b0;
                    end
                end
            end
            ST_BEAT0, ST_BEAT1: begin
                if (bus.err_i) begin
                    finish     = 1'b1;
                    finish_err = LSU_ERR_BUS;
                end else if (bus.rty_i) begin
                    if (retry_cnt == RETRY_LIMIT) begin
                        finish     = 1'b1;
                        finish_err = LSU_ERR_RETRY;
                    end else begin
                        state_n     = ST_WAIT_RTY;
                        stb_n       = 1'b0;
                        retry_cnt_n = retry_cnt + 4'd1;
                    end
                end else if (bus.ack_i) begin
                    if ((state == ST_BEAT0) && crosses) begin
                        state_n       = ST_BEAT1;
                        second_beat_n = 1'b1;
                        adr_n         = adr + 32'(NB);
                        sel_n         = sel1;
                        dat_n         = lat_we ? wdata1 : '0;
                        retry_cnt_n   = '0;
                        rdata0_n      = bus.dat_i;
                    end else begin
                        finish      = 1'b1;
                        finish_data = lat_we ? '0 : load_data;
                    end
                end
            end
            ST_WAIT_RTY: begin
                stb_n   = 1'b1;
                state_n = second_beat ? ST_BEAT1 : ST_BEAT0;
            end
            ST_RESP: begin
                state_n     = ST_IDLE;
                rsp_err_n   = LSU_ERR_NONE;
                rsp_rdata_n = '0;
            end
            default: state_n = ST_IDLE;
        endcase

        if (finish) begin
            state_n     = ST_RESP;
            cyc_n       = 1'b0;
            stb_n       = 1'b0;
            we_n        = 1'b0;
            adr_n       = '0;
            sel_n       = '0;
            dat_n       = '0;
            rsp_valid_n = 1'b1;
            rsp_err_n   = finish_err;
            rsp_rdata_n = finish_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            cyc          <= 1'b0;
            stb          <= 1'b0;
            we           <= 1'b0;
            adr          <= '0;
            sel          <= '0;
            dat          <= '0;
            rsp_valid    <= 1'b0;
            rsp_err      <= LSU_ERR_NONE;
            rsp_rdata    <= '0;
            retry_cnt    <= '0;
            second_beat  <= 1'b0;
            rdata0       <= '0;
            lat_we       <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_size     <= LSU_SIZE_B;
            lat_addr     <= '0;
            lat_wdata    <= '0;
        end else begin
            state       <= state_n;
            cyc         <= cyc_n;
            stb         <= stb_n;
            we          <= we_n;
            adr         <= adr_n;
            sel         <= sel_n;
            dat         <= dat_n;
            rsp_valid   <= rsp_valid_n;
            rsp_err     <= rsp_err_n;
            rsp_rdata   <= rsp_rdata_n;
            retry_cnt   <= retry_cnt_n;
            second_beat <= second_beat_n;
            rdata0      <= rdata0_n;
            if (accept) begin
                lat_we       <= req.req_we_i;
                lat_unsigned <= req.req_unsigned_i;
                lat_size     <= req.req_size_i;
                lat_addr     <= req.req_addr_i;
                lat_wdata    <= req.req_wdata_i;
            end
        end
    end

    assign req.req_ready_o = (state == ST_IDLE);
    assign req.rsp_valid_o = rsp_valid;
    assign req.rsp_rdata_o = rsp_rdata;
    assign req.rsp_err_o   = rsp_err;
    assign bus.cyc_o       = cyc;
    assign bus.stb_o       = stb;
    assign bus.we_o        = we;
    assign bus.adr_o       = adr;
    assign bus.sel_o       = sel;
    assign bus.dat_o       = dat;

endmodule
`default_nettype wire
